// File: rtl/div_sign_salida.sv
// Output stage of the pipelined restoring divider: sign fixup plus a small FWFT result FIFO.
// Optional zero-divisor tagging is enabled by defining DIV_CERO_DETECT_EN.
module div_sign_salida #(
    parameter int BIT_SIZE = 8,
    parameter int DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                RSTa,
    input  logic                Done_in,
    input  logic [BIT_SIZE-1:0] Q_in,
    input  logic [BIT_SIZE-1:0] ACCU_in,
    input  logic [BIT_SIZE-1:0] M_in,
    input  logic                SignNum_in,
    input  logic                SignDen_in,
    input  logic                Ready,
    output logic [BIT_SIZE-1:0] Coc,
    output logic [BIT_SIZE-1:0] Res,
    output logic                Valid,
    output logic                Full,
    output logic                Overflow,
    output logic [15:0]         Count
`ifdef DIV_CERO_DETECT_EN
    ,
    output logic                DivZero
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         count_q, count_d;

    logic [BIT_SIZE-1:0] coc_fix, res_fix;
    logic                push_acc, pop;

    logic [BIT_SIZE-1:0] coc_mem_q [DEPTH];
    logic [BIT_SIZE-1:0] res_mem_q [DEPTH];

    // Sign correction: quotient negative when signs differ, remainder follows the numerator.
    always_comb begin
        coc_fix = (SignNum_in ^ SignDen_in) ? (~Q_in + BIT_SIZE'(1)) : Q_in;
        res_fix = SignNum_in ? (~ACCU_in + BIT_SIZE'(1)) : ACCU_in;
`ifdef DIV_CERO_DETECT_EN
        if (M_in == '0) begin
            coc_fix = '0;
        end
`endif
    end

`ifndef DIV_CERO_DETECT_EN
    logic unused_m;
    assign unused_m = ^M_in;
`endif

    assign Valid    = (occ_q != '0);
    assign Full     = (occ_q == OCC_W'(DEPTH));
    assign pop      = Valid && Ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_acc = Done_in && (!Full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q + 16'd1;
        end
        if (push_acc && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push_acc && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (Done_in && !push_acc) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
        end
    end

`ifdef DIV_CERO_DETECT_EN
    logic dz_mem_q [DEPTH];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                wr_en;
            logic [BIT_SIZE-1:0] coc_d, res_d;
            assign wr_en = push_acc && (wr_ptr_q == PTR_W'(gi));

            always_comb begin
                coc_d = coc_mem_q[gi];
                res_d = res_mem_q[gi];
                if (wr_en) begin
                    coc_d = coc_fix;
                    res_d = res_fix;
                end
            end

            always_ff @(posedge CLK or negedge RSTa) begin
                if (!RSTa) begin
                    coc_mem_q[gi] <= '0;
                    res_mem_q[gi] <= '0;
                end else begin
                    coc_mem_q[gi] <= coc_d;
                    res_mem_q[gi] <= res_d;
                end
            end

`ifdef DIV_CERO_DETECT_EN
            logic dz_d;
            always_comb begin
                dz_d = dz_mem_q[gi];
                if (wr_en) begin
                    dz_d = (M_in == '0);
                end
            end

            always_ff @(posedge CLK or negedge RSTa) begin
                if (!RSTa) begin
                    dz_mem_q[gi] <= 1'b0;
                end else begin
                    dz_mem_q[gi] <= dz_d;
                end
            end
`endif
        end
    endgenerate

    assign Coc      = coc_mem_q[rd_ptr_q];
    assign Res      = res_mem_q[rd_ptr_q];
    assign Overflow = ovf_q;
    assign Count    = count_q;
`ifdef DIV_CERO_DETECT_EN
    assign DivZero  = dz_mem_q[rd_ptr_q];
`endif

endmodule

// File: doc/div_sign_salida.md
# div_sign_salida

Output stage of the pipelined restoring divider. Sits directly downstream of the last iteration stage: captures each completed unsigned quotient/remainder pair with its numerator/denominator sign bits and validity tag. It applies sign correction and buffers results in a small first-word-fall-through FIFO. Results are presented to the consumer through a valid/ready handshake, because the iteration pipeline itself cannot stall.

## Interface
- BIT_SIZE, 8, operand width; equals the width of the Q/M/ACCU buses of the iteration stages
- DEPTH, 4, FIFO entries; power of two, at least 2

- CLK  in  1  clock, rising edge
- RSTa  in  1  asynchronous, active-low reset
- Done_in  in  1  valid tag from last iteration stage; one result per cycle when high
- Q_in  in  BIT_SIZE  unsigned quotient magnitude
- ACCU_in  in  BIT_SIZE  unsigned remainder magnitude
- M_in  in  BIT_SIZE  unsigned divisor magnitude, used only under DIV_CERO_DETECT_EN
- SignNum_in  in  1  numerator sign (1 = negative)
- SignDen_in  in  1  denominator sign (1 = negative)
- Ready  in  1  consumer accepts head entry
- Coc  out  BIT_SIZE  signed quotient, two's complement
- Res  out  BIT_SIZE  signed remainder, two's complement
- Valid  out  1  head entry present
- Full  out  1  FIFO holds DEPTH entries
- Overflow  out  1  sticky: a result was dropped
- Count  out  16  number of results popped, wraps
- DivZero  out  1  head entry had M_in == 0; present only under DIV_CERO_DETECT_EN

## Operation
- Sign fixup is combinational on the inputs and is written into the FIFO on push:
  - Coc = (SignNum_in ^ SignDen_in) ? (~Q_in + 1) : Q_in, truncated to BIT_SIZE.
  - Res = SignNum_in ? (~ACCU_in + 1) : ACCU_in, so the remainder takes the numerator's sign.
- Push condition: Done_in high at a rising edge.
- Pop condition: Valid && Ready at a rising edge.
- FIFO implementation: write and read pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter 0..DEPTH.
  - Valid = occupancy != 0.
  - Full = occupancy == DEPTH.
- Push and pop in the same cycle:
  - Not full: occupancy unchanged; both pointers advance.
  - Full: pop frees a slot, push is accepted, occupancy stays DEPTH, no overflow.
  - Empty: push only. Valid rises next cycle with no fall-through in the same cycle.
- Push while full without a simultaneous pop:
  - The new result is discarded and FIFO contents are unchanged.
  - Overflow is set and stays set until reset.
- Pop while empty: impossible, because Valid is low.
- Count increments by 1 on each pop and wraps from 16'hFFFF to 0.
- Outputs Coc/Res/DivZero show the head entry. When Valid is low they hold the last read location's contents and carry no meaning.

## Timing
- Reset (RSTa low, asynchronous):
  - Pointers, occupancy, Count and Overflow are cleared to 0.
  - Valid = 0, Full = 0, DivZero = 0.
  - Coc = 0 and Res = 0: storage is cleared.
- Reset asserted mid-operation discards all buffered entries. The first push after RSTa deasserts behaves as into an empty FIFO.
- Latency: a result pushed at edge k appears on Coc/Res with Valid high after edge k, i.e. one cycle after Done_in was sampled.
- Throughput: one push and one pop per cycle sustained.
- Handshake: the consumer must treat data as transferred only at an edge where Valid && Ready. Valid never drops without a pop or reset.
- Overflow rises on the edge of the dropped push.

## Configuration
- DIV_CERO_DETECT_EN defined:
  - Each entry stores an extra bit, M_in == 0, and the DivZero port exists.
  - For such entries Coc is forced to 0, replacing the all-ones quotient the iteration stages produce for a zero divisor.
  - Res keeps the signed numerator.
- DIV_CERO_DETECT_EN undefined:
  - No DivZero port, no extra storage bit; M_in is unused.
  - Zero-divisor results pass through with normal sign fixup.

## Test plan
- Sign fixup (BIT_SIZE=8): push Q=7, ACCU=2, SignNum=1, SignDen=0 -> Coc=8'hF9, Res=8'hFE, Valid high next cycle. Push Q=7, ACCU=2, SignNum=1, SignDen=1 -> Coc=8'h07, Res=8'hFE.
- Order and latency: push 3 distinct results on consecutive cycles with Ready=0, then Ready=1 -> popped in push order on 3 consecutive edges; Count=3; Valid low afterwards.
- Full/overflow: DEPTH=4, Ready=0, push 5 results -> Full high after 4th; 5th dropped; Overflow=1; the 4 stored entries are unchanged and pop correctly.
- Simultaneous push/pop at full: FIFO full, Ready=1 and Done_in=1 for 6 cycles -> no overflow, Full stays high, 6 pops, Count=6, output order matches input order.
- Reset mid-stream: 2 entries buffered, pulse RSTa low between edges -> Valid, Full, Overflow, Count, Coc, Res all 0 immediately; next push appears alone.
- DIV_CERO_DETECT_EN: push M_in=0, Q=8'hFF, ACCU=5, SignNum=1 -> DivZero=1, Coc=0, Res=8'hFB. Without the macro -> Coc=8'h01, Res=8'hFB.
